seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 22 ++
 rtl/seq_chunk_adder_add_chunk.sv | 34 +++
 rtl/seq_chunk_adder.sv | 147 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder.
//   - state_t       : controller state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/sum width
//   - DEFAULT_CHUNK : default number of bits added per clock
//   - idx_width()   : width of the chunk index able to hold 0..n without wrapping
package seq_chunk_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n+1)): the index must reach n (all chunks consumed) without wrapping.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_add_chunk.sv
// add_chunk: combinational W-bit ripple-carry adder.
// Ports:
//   a, b   : W-bit addends
//   cin    : carry into bit 0
//   s      : W-bit sum
//   cout   : carry out of bit W-1
//   c_msb  : carry into bit W-1 (used for signed-overflow detection)
module add_chunk
  import seq_chunk_adder_pkg::*;
#(
  parameter int W = DEFAULT_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  genvar gi;
  for (gi = 0; gi < W; gi++) begin : g_bit
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: adds/subtracts two WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, using a single shared add_chunk instance.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start             : begin an operation (accepted only while ready=1)
//   A, B, C0, sub     : operands, carry-in (add mode only) and mode (1 = A-B)
//   ready             : high while idle
//   done              : one-cycle pulse when SUM/Cout/Overflow carry a new result
//   SUM, Cout, Overflow : result, carry out of MSB (1 = no borrow in sub), signed overflow
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             Overflow
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = idx_width(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // effective B (already inverted for subtract)
  logic [WIDTH-1:0] acc_q, acc_d;  // partial sum, filled from the top down
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [CHUNK-1:0] s_chunk;
  logic             cout_chunk;
  logic             cmsb_chunk;
  logic [WIDTH-1:0] acc_shifted;
  logic             last_chunk;

  // Operands shift right each RUN cycle, so the adder always sees the low chunk.
  add_chunk #(.W(CHUNK)) u_add_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (s_chunk),
    .cout  (cout_chunk),
    .c_msb (cmsb_chunk)
  );

  // New chunk enters at the top; after N shifts the first chunk sits at bit 0.
  assign acc_shifted = (acc_q >> CHUNK) | (WIDTH'(s_chunk) << (WIDTH - CHUNK));
  assign last_chunk  = (idx_q == IDXW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : C0;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_shifted;
        carry_d = cout_chunk;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          // Results are published only here so SUM never shows partial data.
          sum_d   = acc_shifted;
          cout_d  = cout_chunk;
          ovf_d   = cout_chunk ^ cmsb_chunk;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign SUM      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 16/4 instance driven from a vector table, random
// operations and hand-written corner sequences (start while busy, reset abort),
// plus an 8/8 instance for the single-chunk case.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start16, c0_16, sub16;
  logic [15:0] a16, b16;
  logic        ready16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start8, c0_8, sub8;
  logic [7:0]  a8, b8;
  logic        ready8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .C0(c0_16),
    .sub(sub16), .ready(ready16), .done(done16), .SUM(sum16), .Cout(cout16),
    .Overflow(ovf16)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .C0(c0_8),
    .sub(sub8), .ready(ready8), .done(done8), .SUM(sum8), .Cout(cout8),
    .Overflow(ovf8)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic        sub;
    res_t        exp;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt16 = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: full-width addition with the subtract transform, overflow from operand signs.
  function automatic res_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic c0, input logic s);
    logic [15:0] be;
    logic [16:0] full;
    res_t        r;
    be     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {16'd0, (s ? 1'b1 : c0)};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (a[15] == be[15]) && (r.sum[15] != a[15]);
    return r;
  endfunction

  // Scoreboard: every done pulse of the 16-bit instance consumes one expected result.
  always @(negedge clk) begin
    res_t e;
    if (done16) begin
      done_cnt16++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 sum=0x%0h", sum16);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", sum16, e.sum);
        check("sb_cout", cout16, e.cout);
        check("sb_ovf", ovf16, e.ovf);
        $display("op16 result sum=0x%04h cout=%0b ovf=%0b", sum16, cout16, ovf16);
      end
    end
  end

  // Called at a negedge with the 16-bit DUT idle; returns at the negedge after it re-enters IDLE.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c0,
                      input logic s, input res_t e, input string tag);
    int edges;
    a16 = a; b16 = b; c0_16 = c0; sub16 = s; start16 = 1'b1;
    exp_q.push_back(e);
    $display("op16 %s A=0x%04h B=0x%04h C0=%0b sub=%0b", tag, a, b, c0, s);
    @(negedge clk);  // E0 has occurred
    start16 = 1'b0;
    edges = 1;
    check({tag, "_ready_busy"}, ready16, 0);
    while (!done16 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!done16) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
    end else begin
      // Counting E0 itself, done appears after edge N+1.
      check({tag, "_latency"}, edges, 5);
      @(negedge clk);
      check({tag, "_ready_after"}, ready16, 1);
      check({tag, "_done_pulse"}, done16, 0);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c0, input logic s,
                     input logic [7:0] esum, input logic ecout, input logic eovf, input string tag);
    int edges;
    a8 = a; b8 = b; c0_8 = c0; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    while (!done8 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    if (!done8) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
    end else begin
      check({tag, "_latency"}, edges, 2);
      check({tag, "_sum"}, sum8, esum);
      check({tag, "_cout"}, cout8, ecout);
      check({tag, "_ovf"}, ovf8, eovf);
      $display("op8 %s A=0x%02h B=0x%02h sum=0x%02h cout=%0b ovf=%0b", tag, a, b, sum8, cout8, ovf8);
      @(negedge clk);
      check({tag, "_ready_after"}, ready8, 1);
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   cnt0;
    logic [15:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};  // C0 ignored in sub
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    vecs[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vecs[8] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};

    reset = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; c0_16 = 1'b0; sub16 = 1'b0;
    start8 = 1'b0;  a8 = '0;  b8 = '0;  c0_8 = 1'b0;  sub8 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ready", ready16, 1);
    check("rst_done", done16, 0);
    check("rst_sum", sum16, 0);
    check("rst_cout", cout16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_ready8", ready8, 1);

    // reset and start together: reset wins, DUT stays idle
    start16 = 1'b1; a16 = 16'h1111; b16 = 16'h1111;
    @(negedge clk);
    start16 = 1'b0;
    reset = 1'b0;
    check("rst_start_ready", ready16, 1);
    @(negedge clk);
    check("rst_start_idle", ready16, 1);

    for (int i = 0; i < 10; i++)
      op16(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      op16(ra, rb, rc, rs, model16(ra, rb, rc, rs), $sformatf("rnd%0d", i));
    end

    // start pulsed again at E2 with different operands: must be ignored
    cnt0 = done_cnt16;
    a16 = 16'h1111; b16 = 16'h2222; c0_16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    exp_q.push_back('{16'h3333, 1'b0, 1'b0});
    $display("op16 busy_start A=0x1111 B=0x2222, second start at E2");
    @(negedge clk);  // after E0
    start16 = 1'b0;
    @(negedge clk);  // after E1
    a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; start16 = 1'b1;
    @(negedge clk);  // after E2
    start16 = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_start_done_count", done_cnt16 - cnt0, 1);
    check("busy_start_ready", ready16, 1);

    // reset at E3 aborts: no done, results cleared
    cnt0 = done_cnt16;
    a16 = 16'h4444; b16 = 16'h1111; c0_16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    $display("op16 reset_abort A=0x4444 B=0x1111, reset at E3");
    @(negedge clk);  // after E0
    start16 = 1'b0;
    @(negedge clk);  // after E1
    @(negedge clk);  // after E2
    reset = 1'b1;
    @(negedge clk);  // after E3
    reset = 1'b0;
    check("abort_ready", ready16, 1);
    check("abort_sum", sum16, 0);
    check("abort_done", done16, 0);
    repeat (8) @(negedge clk);
    check("abort_done_count", done_cnt16 - cnt0, 0);
    op16(16'h0102, 16'h0304, 1'b1, 1'b0, '{16'h0407, 1'b0, 1'b0}, "after_abort");

    // single-chunk instance
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "w8_min_add");
    op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "w8_sub");
    op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "w8_cin_ovf");

    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
